// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, byte-lane writes, optional wait states.
// Define DM_RANGE_CHECK_EN to flag out-of-range addresses and unsupported lane masks.
module dm_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wea,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [3:0]  wea_q;
  logic [31:0] wdata_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic        illegal;

  logic [31:0] mem [DEPTH];

  assign idx = addr_q[ADDR_WIDTH+1:2];

`ifdef DM_RANGE_CHECK_EN
  logic wea_ok;
  logic unused_addr_bits;

  always_comb begin
    case (wea_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: wea_ok = 1'b1;
      default:                   wea_ok = 1'b0;
    endcase
  end

  assign illegal          = (addr_q[31:ADDR_WIDTH+2] != '0) || !wea_ok;
  assign unused_addr_bits = ^addr_q[1:0];
`else
  logic unused_addr_bits;

  // Upper address bits are dropped, so addresses alias modulo the array size.
  assign illegal          = 1'b0;
  assign unused_addr_bits = ^{addr_q[31:ADDR_WIDTH+2], addr_q[1:0]};
`endif

  // Held low during reset even though the state register already reads IDLE.
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wea_q   <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wea_q   <= req_wea;
        wdata_q <= req_wdata;
      end
    end
  end

  // NOTE: the array has no reset; an asynchronous reset forces IDLE, so an interrupted
  // ACCESS never reaches its closing edge and the write is dropped.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && !illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (wea_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'h0;
    end else if (state_q == ACCESS) begin
      rsp_rdata <= (wea_q == 4'b0000 && !illegal) ? mem[idx] : 32'h0;
    end
  end

`ifdef DM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (state_q == ACCESS) begin
      rsp_err <= illegal;
    end
  end
`else
  assign rsp_err = illegal;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with one wait state, one with none.
// Expectations for the range test follow DM_RANGE_CHECK_EN.
module tb_dm_responder;

`ifdef DM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_wea;

  logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_wea;

  int n_checks = 0;
  int n_errors = 0;

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .req_wea(a_req_wea), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .req_wea(z_req_wea), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request to the one-wait instance and return just after the accept edge.
  task automatic send(input logic [31:0] addr, input logic [3:0] wea, input logic [31:0] wdata);
    int n = 0;
    a_req_valid = 1'b1;
    a_req_addr  = addr;
    a_req_wea   = wea;
    a_req_wdata = wdata;
    while (!a_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: req_ready still %b after %0d cycles, required 1", a_req_ready, n);
    end
    @(posedge clk);
    #1 a_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!a_rsp_valid && lat < 20);
  endtask

  task automatic xact(input string tag, input logic [31:0] addr, input logic [3:0] wea,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
    int lat;
    send(addr, wea, wdata);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_rdata"}, a_rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, a_rsp_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int k;
    int cyc;
    int acc [2];

    rst = 1'b1;
    a_req_valid = 1'b0; a_req_addr = '0; a_req_wea = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_addr = '0; z_req_wea = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("idle_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);

    // Word write then read
    xact("wr10", 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("rd10", 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte and halfword lanes
    xact("wr20", 32'h20, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("wrb22", 32'h22, 4'b0100, 32'h00AB0000, 32'h0, 1'b0);
    xact("rd20a", 32'h20, 4'b0000, 32'h0, 32'hDEABBEEF, 1'b0);
    xact("wrh20", 32'h20, 4'b1100, 32'h12340000, 32'h0, 1'b0);
    xact("rd20b", 32'h20, 4'b0000, 32'h0, 32'h1234BEEF, 1'b0);

    // Backpressure: response held for five cycles
    a_rsp_ready = 1'b0;
    send(32'h20, 4'b0000, 32'h0);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, a_rsp_valid}, 32'd1);
      check("bp_rdata", a_rsp_rdata, 32'h1234BEEF);
      check("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("bp_done_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("bp_done_rdata", a_rsp_rdata, 32'h1234BEEF);

    // Zero wait states: back-to-back write then read with rsp_ready tied high
    acc[0] = 0;
    acc[1] = 0;
    k = 0;
    cyc = 0;
    z_req_valid = 1'b1;
    z_req_addr  = 32'h40;
    z_req_wea   = 4'b1111;
    z_req_wdata = 32'hA5A55A5A;
    while (k < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (z_req_ready) begin
        acc[k] = cyc;
        k++;
        @(posedge clk);
        #1;
        z_req_wea   = 4'b0000;
        z_req_wdata = 32'h0;
        if (k == 2) z_req_valid = 1'b0;
      end
    end
    check("z_spacing", 32'(acc[1] - acc[0]), 32'd3);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!z_rsp_valid && lat < 20);
    check("z_lat", 32'(lat), 32'd2);
    check("z_rdata", z_rsp_rdata, 32'hA5A55A5A);
    check("z_err", {31'd0, z_rsp_err}, 32'd0);
    @(negedge clk);

    // Reset during ACCESS drops the write
    xact("wr30", 32'h30, 4'b1111, 32'h11111111, 32'h0, 1'b0);
    send(32'h30, 4'b1111, 32'h55555555);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstacc_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rstacc_req_ready", {31'd0, a_req_ready}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rstacc_idle", {31'd0, a_req_ready}, 32'd1);
    xact("rd30", 32'h30, 4'b0000, 32'h0, 32'h11111111, 1'b0);

    // Range check (or aliasing when the check is compiled out)
    xact("wr0", 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("wr1000", 32'h1000, 4'b1111, 32'h0BADBEEF, 32'h0, RANGE_EN);
    xact("rd0a", 32'h0, 4'b0000, 32'h0, RANGE_EN ? 32'hCAFEF00D : 32'h0BADBEEF, 1'b0);
    xact("wr0101", 32'h0, 4'b0101, 32'hFFFFFFFF, 32'h0, RANGE_EN);
    xact("rd0b", 32'h0, 4'b0000, 32'h0, RANGE_EN ? 32'hCAFEF00D : 32'h0BFFBEFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
